// File: rtl/ex_pkg.sv
// Shared encodings for the execute side of the pipeline: ALU control,
// ALUOp, R-type funct codes and the operand forwarding select.
package ex_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding select for the ID/EX stage; the nearer producer
// (EX/MEM) wins over MEM/WB, and register 0 is never forwarded.
module forward_unit
    import ex_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    output fwd_sel_t          fwd_rs,
    output fwd_sel_t          fwd_rt
);

    logic ex_ok;
    logic wb_ok;

    assign ex_ok = exmem_reg_write && (exmem_rd != '0);
    assign wb_ok = memwb_reg_write && (memwb_rd != '0);

    always_comb begin
        fwd_rs = FWD_REG;
        if (ex_ok && (exmem_rd == rs_addr)) begin
            fwd_rs = FWD_EXMEM;
        end else if (wb_ok && (memwb_rd == rs_addr)) begin
            fwd_rs = FWD_MEMWB;
        end
    end

    always_comb begin
        fwd_rt = FWD_REG;
        if (ex_ok && (exmem_rd == rt_addr)) begin
            fwd_rt = FWD_EXMEM;
        end else if (wb_ok && (memwb_rd == rt_addr)) begin
            fwd_rt = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with ALU control decode.
// Define ID_EX_FORWARD_EN to forward EX/MEM and MEM/WB results onto operands.
module id_ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [REG_AW-1:0] rs_addr_i,
    input  logic [REG_AW-1:0] rt_addr_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic [1:0]        alu_op_i,
    input  logic              alu_src_i,
    input  logic              reg_dst_i,
    input  logic              reg_write_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              mem_to_reg_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_data_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data1_o,
    output logic [DATA_W-1:0] data2_o,
    output logic [2:0]        ALUControl_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [REG_AW-1:0] wb_addr_o,
    output logic [REG_AW-1:0] rt_addr_o,
    output logic              reg_write_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              mem_to_reg_o
);

    logic              valid_q;
    logic [DATA_W-1:0] rs_q;
    logic [DATA_W-1:0] rt_q;
    logic [DATA_W-1:0] imm_q;
    logic [REG_AW-1:0] rs_addr_q;
    logic [REG_AW-1:0] rt_addr_q;
    logic [REG_AW-1:0] rd_q;
    logic [1:0]        alu_op_q;
    logic              alu_src_q;
    logic              reg_dst_q;
    logic              reg_write_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              mem_to_reg_q;

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic [2:0]        alu_ctrl;

    // Flush and reset both leave a fully zeroed bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || flush_i) begin
            valid_q      <= 1'b0;
            rs_q         <= '0;
            rt_q         <= '0;
            imm_q        <= '0;
            rs_addr_q    <= '0;
            rt_addr_q    <= '0;
            rd_q         <= '0;
            alu_op_q     <= '0;
            alu_src_q    <= 1'b0;
            reg_dst_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else if (!stall_i) begin
            valid_q      <= valid_i;
            rs_q         <= rs_data_i;
            rt_q         <= rt_data_i;
            imm_q        <= imm_i;
            rs_addr_q    <= rs_addr_i;
            rt_addr_q    <= rt_addr_i;
            rd_q         <= rd_addr_i;
            alu_op_q     <= alu_op_i;
            alu_src_q    <= alu_src_i;
            reg_dst_q    <= reg_dst_i;
            reg_write_q  <= reg_write_i;
            mem_read_q   <= mem_read_i;
            mem_write_q  <= mem_write_i;
            mem_to_reg_q <= mem_to_reg_i;
        end
    end

`ifdef ID_EX_FORWARD_EN
    fwd_sel_t sel_rs;
    fwd_sel_t sel_rt;

    forward_unit #(
        .REG_AW(REG_AW)
    ) u_fwd (
        .rs_addr        (rs_addr_q),
        .rt_addr        (rt_addr_q),
        .exmem_reg_write(exmem_reg_write_i),
        .exmem_rd       (exmem_rd_i),
        .memwb_reg_write(memwb_reg_write_i),
        .memwb_rd       (memwb_rd_i),
        .fwd_rs         (sel_rs),
        .fwd_rt         (sel_rt)
    );

    always_comb begin
        fwd_rs = rs_q;
        case (sel_rs)
            FWD_EXMEM: fwd_rs = exmem_data_i;
            FWD_MEMWB: fwd_rs = memwb_data_i;
            default:   fwd_rs = rs_q;
        endcase
    end

    always_comb begin
        fwd_rt = rt_q;
        case (sel_rt)
            FWD_EXMEM: fwd_rt = exmem_data_i;
            FWD_MEMWB: fwd_rt = memwb_data_i;
            default:   fwd_rt = rt_q;
        endcase
    end
`else
    // Hazards are stalled upstream; the bypass inputs have no effect.
    logic unused_fwd;

    assign unused_fwd = ^{exmem_reg_write_i, exmem_rd_i, exmem_data_i,
                          memwb_reg_write_i, memwb_rd_i, memwb_data_i,
                          rs_addr_q};
    assign fwd_rs = rs_q;
    assign fwd_rt = rt_q;
`endif

    always_comb begin
        alu_ctrl = ALU_ADD;
        unique case (alu_op_q)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_OR:  alu_ctrl = ALU_OR;
            ALUOP_RTYPE: begin
                case (imm_q[5:0])
                    FUNCT_ADD: alu_ctrl = ALU_ADD;
                    FUNCT_SUB: alu_ctrl = ALU_SUB;
                    FUNCT_AND: alu_ctrl = ALU_AND;
                    FUNCT_OR:  alu_ctrl = ALU_OR;
                    FUNCT_SLT: alu_ctrl = ALU_SLT;
                    default:   alu_ctrl = ALU_ADD;
                endcase
            end
        endcase
    end

    assign valid_o      = valid_q;
    assign data1_o      = fwd_rs;
    assign data2_o      = alu_src_q ? imm_q : fwd_rt;
    assign store_data_o = fwd_rt;
    assign ALUControl_o = alu_ctrl;
    assign wb_addr_o    = reg_dst_q ? rd_q : rt_addr_q;
    assign rt_addr_o    = rt_addr_q;
    assign reg_write_o  = reg_write_q;
    assign mem_read_o   = mem_read_q;
    assign mem_write_o  = mem_write_q;
    assign mem_to_reg_o = mem_to_reg_q;

endmodule
